// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the MIPS unified-memory arbiter.
package mips_mem_pkg;

  localparam int unsigned MIPS_ADDR_W = 32;
  localparam int unsigned MIPS_DATA_W = 32;
  localparam int unsigned STREAK_W    = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_arb_pick.sv
// Winner selection between fetch and data ports, with the streak counter
// that bounds consecutive data wins while fetch is waiting.
module mips_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   upd,
  output owner_t win_c,
  output logic   any_c
);

  logic [STREAK_W-1:0] streak;
  logic                at_limit;

  assign at_limit = (streak == STREAK_W'(MAX_STREAK));
  assign any_c    = if_req | d_req;

  // Data wins unless fetch has waited through MAX_STREAK data grants.
  always_comb begin
    win_c = OWN_IF;
    if (d_req && !(if_req && at_limit)) begin
      win_c = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (upd) begin
      if (!if_req || (win_c == OWN_IF)) begin
        streak <= '0;
      end else if (!at_limit) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch and data ports:
// one transaction at a time, data priority, fetch starvation guard.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MIPS_ADDR_W,
  parameter int unsigned DATA_W     = MIPS_DATA_W,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state, state_nx;
  owner_t     owner, win_c;
  logic       any_c, arb_c, accept_c, resp_c;

  mips_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .upd    (arb_c),
    .win_c  (win_c),
    .any_c  (any_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Arbitration happens in IDLE and on the response cycle, so a pending
  // request goes straight back to REQ with no idle gap.
  always_comb begin
    state_nx = state;
    arb_c    = 1'b0;
    accept_c = 1'b0;
    resp_c   = 1'b0;
    case (state)
      IDLE: begin
        if (any_c) begin
          arb_c    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          accept_c = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          resp_c   = 1'b1;
          arb_c    = 1'b1;
          state_nx = any_c ? REQ : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign if_gnt = accept_c && (owner == OWN_IF) && !rst;
  assign d_gnt  = accept_c && (owner == OWN_D)  && !rst;

  // Command latch: loaded only when a winner is chosen, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (arb_c && any_c) begin
      owner     <= win_c;
      mem_we    <= (win_c == OWN_D) ? d_we    : 1'b0;
      mem_addr  <= (win_c == OWN_D) ? d_addr  : if_addr;
      mem_wdata <= (win_c == OWN_D) ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_req   <= (state_nx == REQ);
      busy      <= (state_nx != IDLE);
      if_rvalid <= resp_c && (owner == OWN_IF);
      d_rvalid  <= resp_c && (owner == OWN_D);
      if (resp_c && (owner == OWN_IF)) if_rdata <= mem_rdata;
      // Store completions return zero data.
      if (resp_c && (owner == OWN_D))  d_rdata  <= mem_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a small reactive memory model.
module tb_mips_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready  = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;

  int checks   = 0;
  int failures = 0;

  // Memory model knobs, only changed while no transaction is in flight.
  int            ready_delay  = 0;
  int            req_cycles   = 0;
  logic          mem_en       = 1'b1;
  logic          force_rvalid = 1'b0;
  logic          use_fixed    = 1'b0;
  logic [DW-1:0] fixed_val    = '0;
  logic          acc_q        = 1'b0;
  logic [AW-1:0] acc_addr     = '0;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    acc_q    = mem_req && mem_ready;
    acc_addr = mem_addr;
  end

  // Ready after ready_delay REQ cycles; respond one cycle after acceptance.
  always @(posedge clk) begin
    #1;
    mem_rvalid = (acc_q && mem_en) || force_rvalid;
    mem_rdata  = use_fixed ? fixed_val : acc_addr + 32'd1;
    if (mem_req) begin
      mem_ready  = (req_cycles >= ready_delay);
      req_cycles = req_cycles + 1;
    end else begin
      mem_ready  = 1'b0;
      req_cycles = 0;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic do_reset;
    cyc;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    cyc;
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    cyc;
    cyc;
    mid;
    checks++;
    if ({mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin
      failures++;
      $display("FAIL reset_cmd: got %h want 0", {mem_we, mem_addr, mem_wdata});
    end
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_single_load;
    do_reset;
    use_fixed = 1'b1; fixed_val = 32'd5; ready_delay = 0;
    cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    mid;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL load_c0_memreq: got %b want 0", mem_req);
    end
    cyc;
    mid;
    checks++;
    if ({d_gnt, mem_req, mem_we, if_gnt} !== 4'b1100) begin
      failures++;
      $display("FAIL load_c1_gnt: got %b want 1100", {d_gnt, mem_req, mem_we, if_gnt});
    end
    checks++;
    if (mem_addr !== 32'd8) begin
      failures++;
      $display("FAIL load_c1_addr: got %h want 8", mem_addr);
    end
    cyc;
    d_req = 1'b0;
    mid;
    checks++;
    if ({d_rvalid, busy, mem_req} !== 3'b010) begin
      failures++;
      $display("FAIL load_c2_resp: got %b want 010", {d_rvalid, busy, mem_req});
    end
    cyc;
    mid;
    checks++;
    if ({d_rvalid, if_rvalid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL load_c3_rvalid: got %b want 100", {d_rvalid, if_rvalid, busy});
    end
    checks++;
    if (d_rdata !== 32'd5 || if_rdata !== 32'd0) begin
      failures++;
      $display("FAIL load_c3_rdata: got d=%h if=%h want d=5 if=0", d_rdata, if_rdata);
    end
    cyc;
    mid;
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL load_c4_pulse: got %b want 0", d_rvalid);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_store;
    logic got;
    do_reset;
    use_fixed = 1'b1; fixed_val = 32'hdead_beef;
    cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'h6;
    cyc;
    mid;
    checks++;
    if ({d_gnt, mem_req, mem_we} !== 3'b111) begin
      failures++;
      $display("FAIL store_gnt: got %b want 111", {d_gnt, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 32'd12 || mem_wdata !== 32'h6) begin
      failures++;
      $display("FAIL store_cmd: got addr=%h wdata=%h want c/6", mem_addr, mem_wdata);
    end
    cyc;
    d_req = 1'b0; d_we = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      mid;
      if (d_rvalid) got = 1'b1;
      else cyc;
    end
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL store_rvalid_timeout: got %b want 1", got);
    end
    checks++;
    if (d_rdata !== 32'd0) begin
      failures++;
      $display("FAIL store_rdata: got %h want 0", d_rdata);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_backpressure;
    logic got;
    do_reset;
    ready_delay = 3;
    cyc;
    if_req = 1'b1; if_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      cyc;
      mid;
      checks++;
      if ({mem_req, mem_addr, if_gnt} !== {1'b1, 32'h40, (i == 4)}) begin
        failures++;
        $display("FAIL bp_cycle%0d: got req=%b addr=%h gnt=%b want 1/40/%0d", i, mem_req, mem_addr, if_gnt, (i == 4));
      end
    end
    cyc;
    if_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      mid;
      if (if_rvalid) got = 1'b1;
      else cyc;
    end
    checks++;
    if (got !== 1'b1 || if_rdata !== 32'h41) begin
      failures++;
      $display("FAIL bp_rdata: got v=%b d=%h want 1/41", got, if_rdata);
    end
    ready_delay = 0;
  endtask

  task automatic test_reset_resp;
    do_reset;
    mem_en = 1'b0;
    cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd4;
    cyc;
    mid;
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rr_gnt: got %b want 1", d_gnt);
    end
    cyc;
    d_req = 1'b0; rst = 1'b1;
    mid;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rr_busy_before: got %b want 1", busy);
    end
    cyc;
    rst = 1'b0;
    mid;
    checks++;
    if ({busy, d_rvalid, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL rr_after_reset: got %b want 000", {busy, d_rvalid, mem_req});
    end
    force_rvalid = 1'b1;
    cyc;
    mid;
    force_rvalid = 1'b0;
    cyc;
    mid;
    checks++;
    if ({busy, d_rvalid, if_rvalid, mem_req} !== 4'b0000) begin
      failures++;
      $display("FAIL rr_late_rvalid: got %b want 0000", {busy, d_rvalid, if_rvalid, mem_req});
    end
    mem_en = 1'b1;
  endtask

  task automatic test_streak;
    logic [9:0] seq;
    int         n;
    do_reset;
    seq = '0; n = 0;
    cyc;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int i = 0; i < 200 && n < 10; i++) begin
      cyc;
      mid;
      if (d_gnt || if_gnt) begin
        seq = {seq[8:0], d_gnt};
        n++;
      end
    end
    checks++;
    if (n !== 10 || seq !== 10'b1111011110) begin
      failures++;
      $display("FAIL streak_order: got n=%0d seq=%b want 10/1111011110", n, seq);
    end
    cyc;
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) cyc;
  endtask

  task automatic test_back_to_back;
    int   idx, nr;
    logic gnt_prev;
    do_reset;
    idx = 0; nr = 0; gnt_prev = 1'b0;
    cyc;
    if_req = 1'b1; if_addr = 32'd0;
    for (int c = 1; c <= 40 && nr < 3; c++) begin
      cyc;
      if (gnt_prev) idx++;
      if_req  = (idx < 3);
      if_addr = 32'(idx * 4);
      mid;
      gnt_prev = if_gnt;
      if (if_rvalid) begin
        checks++;
        if (if_rdata !== 32'(nr * 4 + 1)) begin
          failures++;
          $display("FAIL stream_rdata%0d: got %h want %h", nr, if_rdata, nr * 4 + 1);
        end
        if (nr < 2) begin
          checks++;
          if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL stream_gap%0d: got mem_req=%b want 1", nr, mem_req);
          end
        end
        nr++;
      end
    end
    checks++;
    if (nr !== 3) begin
      failures++;
      $display("FAIL stream_count: got %0d want 3", nr);
    end
  endtask

  initial begin
    test_reset;
    test_single_load;
    test_store;
    test_backpressure;
    test_reset_resp;
    test_streak;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
